// File: rtl/oam_dma_controller.sv
// Sprite DMA: copies TRANSFER_COUNT bytes from {page, index} to OAMDATA, stalling the CPU. Stall 1+2*N cycles.
// Optional OAMDMA_ODD_ALIGN_EN inserts one ALIGN cycle when triggered on an odd-parity cycle.
module oam_dma_controller #(
  parameter logic [15:0] TRIGGER_ADDRESS = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDRESS = 16'h2004,
  parameter int          TRANSFER_COUNT  = 256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  output logic        o_cpu_en,
  output logic        o_bus_rw,
  output logic [15:0] o_bus_address,
  output logic [7:0]  o_bus_data,
  input  logic [7:0]  i_bus_data,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
`ifdef OAMDMA_ODD_ALIGN_EN
    ALIGN = 3'd2,
`endif
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam logic [8:0] LAST_COUNT = 9'(TRANSFER_COUNT);

  state_t     state, state_nxt;
  logic [8:0] index, index_nxt;
  logic [7:0] page, page_nxt;
  logic [7:0] latch, latch_nxt;
  logic       cpu_en_nxt;
  logic [8:0] index_inc;
  logic       trigger;

  assign index_inc = index + 9'd1;
  assign trigger   = (i_cpu_rw == 1'b0) && (i_cpu_address == TRIGGER_ADDRESS);

`ifdef OAMDMA_ODD_ALIGN_EN
  logic parity;
  logic align_req, align_req_nxt;

  // Free-running cycle parity, 0 in the first cycle after reset release.
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      parity    <= 1'b0;
      align_req <= 1'b0;
    end else begin
      parity    <= ~parity;
      align_req <= align_req_nxt;
    end
  end
`endif

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      index    <= 9'd0;
      page     <= 8'd0;
      latch    <= 8'd0;
      o_cpu_en <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      index    <= index_nxt;
      page     <= page_nxt;
      latch    <= latch_nxt;
      o_cpu_en <= cpu_en_nxt;
      o_busy   <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt  = state;
    index_nxt  = index;
    page_nxt   = page;
    latch_nxt  = latch;
    cpu_en_nxt = o_cpu_en;
`ifdef OAMDMA_ODD_ALIGN_EN
    align_req_nxt = align_req;
`endif
    case (state)
      IDLE: begin
        if (trigger) begin
          page_nxt   = i_cpu_data;
          index_nxt  = 9'd0;
          cpu_en_nxt = 1'b0;
          state_nxt  = HALT;
`ifdef OAMDMA_ODD_ALIGN_EN
          align_req_nxt = parity;
`endif
        end
      end
      HALT: begin
`ifdef OAMDMA_ODD_ALIGN_EN
        state_nxt = align_req ? ALIGN : READ;
`else
        state_nxt = READ;
`endif
      end
`ifdef OAMDMA_ODD_ALIGN_EN
      ALIGN: begin
        state_nxt = READ;
      end
`endif
      READ: begin
        latch_nxt = i_bus_data;
        state_nxt = WRITE;
      end
      WRITE: begin
        index_nxt = index_inc;
        if (index_inc == LAST_COUNT) begin
          state_nxt  = IDLE;
          cpu_en_nxt = 1'b1;
        end else begin
          state_nxt = READ;
        end
      end
      default: begin
        state_nxt  = IDLE;
        cpu_en_nxt = 1'b1;
      end
    endcase
  end

  // Dummy cycles reuse the stalled CPU address but never write.
  always_comb begin
    o_bus_rw      = i_cpu_rw;
    o_bus_address = i_cpu_address;
    o_bus_data    = i_cpu_data;
    case (state)
      IDLE: begin
        o_bus_rw      = i_cpu_rw;
        o_bus_address = i_cpu_address;
        o_bus_data    = i_cpu_data;
      end
      READ: begin
        o_bus_rw      = 1'b1;
        o_bus_address = {page, index[7:0]};
        o_bus_data    = latch;
      end
      WRITE: begin
        o_bus_rw      = 1'b0;
        o_bus_address = OAMDATA_ADDRESS;
        o_bus_data    = latch;
      end
      default: begin
        o_bus_rw      = 1'b1;
        o_bus_address = i_cpu_address;
        o_bus_data    = latch;
      end
    endcase
  end

endmodule
